// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with level, almost-full/empty
// thresholds and sticky overflow/underflow flags.
// Optional feature macro: FIFO_PARAM_FWFT_EN (first-word fall-through on dout).
// Without the macro, dout is a registered read port with one cycle of latency.
module fifo_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              write,
    input  logic              read,
    input  logic              clear_err,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LV  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] LV_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              aempty_q, aempty_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              rd_ok;
    logic              wr_ok;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok = read && !empty_q;
    assign wr_ok = write && (!full_q || rd_ok);

    // Next-state pointers, level, and flags derived from the next level.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        level_d  = level_q;
        if (wr_ok) begin
            head_d = head_q + PTR_ONE;
        end
        if (rd_ok) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (wr_ok && !rd_ok) begin
            level_d = level_q + LV_ONE;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - LV_ONE;
        end
        empty_d  = (level_d == '0);
        full_d   = (level_d == DEPTH_LV);
        aempty_d = (level_d <= AEMPTY_LV);
        afull_d  = (level_d >= AFULL_LV);
        // A new error in the same cycle as clear_err keeps the flag set.
        if (write && !wr_ok) begin
            ovf_d = 1'b1;
        end else if (clear_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (read && !rd_ok) begin
            unf_d = 1'b1;
        end else if (clear_err) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents survive reset, writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[head_q] <= din;
        end
    end

`ifdef FIFO_PARAM_FWFT_EN
    // Head-of-queue word is presented directly; meaningless while empty.
    assign dout = mem[tail_q];
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    // Read port captures the head word on an accepted read, else holds.
    always_comb begin
        dout_d = dout_q;
        if (rd_ok) begin
            dout_d = mem[tail_q];
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
